// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue stage: per-register pending-write counters gate RAW hazards,
// one-entry output register toward execute. Optional macro ISSUE_SCOREBOARD_BYPASS_EN.
module issue_scoreboard #(
  parameter int NREG   = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 2,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_write_reg,
  input  logic              in_memory_read,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_write_reg,
  output logic              out_memory_read,
  output logic [DATA_W-1:0] out_payload,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              flush,
  output logic              stall_raw
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  r_cnt     [NREG];
  logic [CNT_W-1:0]  w_cnt_nxt [NREG];

  logic              r_out_valid;
  logic [REG_W-1:0]  r_out_rd;
  logic              r_out_write_reg;
  logic              r_out_memory_read;
  logic [DATA_W-1:0] r_out_payload;

  logic [CNT_W-1:0]  w_cnt_rs1;
  logic [CNT_W-1:0]  w_cnt_rs2;
  logic [CNT_W-1:0]  w_cnt_rd;
  logic              w_byp_rs1;
  logic              w_byp_rs2;
  logic              w_busy_rs1;
  logic              w_busy_rs2;
  logic              w_raw;
  logic              w_sat;
  logic              w_fire;

  assign w_cnt_rs1 = r_cnt[in_rs1];
  assign w_cnt_rs2 = r_cnt[in_rs2];
  assign w_cnt_rd  = r_cnt[in_rd];

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  // Last outstanding writer retiring this cycle: the source is ready in time.
  assign w_byp_rs1 = wb_valid && (wb_rd == in_rs1) && (w_cnt_rs1 == CNT_W'(1));
  assign w_byp_rs2 = wb_valid && (wb_rd == in_rs2) && (w_cnt_rs2 == CNT_W'(1));
`else
  assign w_byp_rs1 = 1'b0;
  assign w_byp_rs2 = 1'b0;
`endif

  assign w_busy_rs1 = in_use_rs1 && (in_rs1 != '0) && (w_cnt_rs1 != '0) && !w_byp_rs1;
  assign w_busy_rs2 = in_use_rs2 && (in_rs2 != '0) && (w_cnt_rs2 != '0) && !w_byp_rs2;
  assign w_raw      = w_busy_rs1 || w_busy_rs2;
  assign w_sat      = in_write_reg && (in_rd != '0) && (w_cnt_rd == CNT_MAX);

  assign in_ready  = reset && !flush && !w_raw && !w_sat && (!r_out_valid || out_ready);
  assign w_fire    = in_valid && in_ready;
  assign stall_raw = in_valid && (w_raw || w_sat) && reset;

  // Net delta per register: issue adds one, writeback and squash each remove one.
  always_comb begin : p_cnt_nxt
    logic             w_inc;
    logic [1:0]       w_dec;
    logic [CNT_W:0]   w_up;
    logic [CNT_W:0]   w_dn;
    logic [CNT_W:0]   w_diff;
    w_inc  = 1'b0;
    w_dec  = '0;
    w_up   = '0;
    w_dn   = '0;
    w_diff = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
    end
    w_cnt_nxt[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      w_inc  = w_fire && in_write_reg && (in_rd == REG_W'(i));
      w_dec  = 2'(wb_valid && (wb_rd == REG_W'(i)))
             + 2'(flush && r_out_valid && r_out_write_reg && (r_out_rd == REG_W'(i)));
      w_up   = {1'b0, r_cnt[i]} + (CNT_W+1)'(w_inc);
      w_dn   = (CNT_W+1)'(w_dec);
      w_diff = w_up - w_dn;
      if (w_up <= w_dn) begin
        w_cnt_nxt[i] = '0;
      end else if (w_diff > {1'b0, CNT_MAX}) begin
        w_cnt_nxt[i] = CNT_MAX;
      end else begin
        w_cnt_nxt[i] = w_diff[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid       <= 1'b0;
      r_out_rd          <= '0;
      r_out_write_reg   <= 1'b0;
      r_out_memory_read <= 1'b0;
      r_out_payload     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid       <= 1'b1;
      r_out_rd          <= in_rd;
      r_out_write_reg   <= in_write_reg;
      r_out_memory_read <= in_memory_read;
      r_out_payload     <= in_payload;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_rd          = r_out_rd;
  assign out_write_reg   = r_out_write_reg;
  assign out_memory_read = r_out_memory_read;
  assign out_payload     = r_out_payload;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Decode-to-execute issue stage. Takes decoded instructions with their `write_reg` / `memory_read` classification and register indices.
- Tracks in-flight register writes in a per-register pending counter and stalls RAW hazards.
- Holds one issued instruction in an output register with a valid/ready handshake toward execute.
- Writeback or squash notifications release pending writes.

Parameters:
- NREG, 32, number of architectural integer registers; x0 is never tracked.
- REG_W, 5, register index width.
- CNT_W, 2, pending-counter width; max outstanding writers per register = 2^CNT_W-1.
- DATA_W, 96, opaque payload width (pc + instruction word) passed through.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  issue accepts this cycle.
- in_rs1  in  REG_W  source 1 index.
- in_rs2  in  REG_W  source 2 index.
- in_use_rs1  in  1  source 1 is read.
- in_use_rs2  in  1  source 2 is read.
- in_rd  in  REG_W  destination index.
- in_write_reg  in  1  instruction writes rd (from decode classification).
- in_memory_read  in  1  instruction is a load.
- in_payload  in  DATA_W  passthrough.
- out_valid  out  1  issued instruction available to execute.
- out_ready  in  1  execute accepts.
- out_rd  out  REG_W  registered rd.
- out_write_reg  out  1  registered write flag.
- out_memory_read  out  1  registered load flag.
- out_payload  out  DATA_W  registered payload.
- wb_valid  in  1  one writer retired or squashed downstream.
- wb_rd  in  REG_W  its rd.
- flush  in  1  squash entry in output register and block issue this cycle.
- stall_raw  out  1  in_valid blocked by a hazard (perf/debug).

Behaviour:
- Reset (reset==0, async):
  - out_valid=0; out_rd=0; out_write_reg=0; out_memory_read=0; out_payload=0.
  - All counters 0.
  - in_ready=0 and stall_raw=0 while reset is asserted.
  - Reset mid-handshake discards the held entry; no pending state survives.
- Hazard, combinational:
  - src_busy(r) = use && r!=0 && cnt[r]!=0.
  - raw = src_busy(rs1) || src_busy(rs2).
  - sat = in_write_reg && in_rd!=0 && cnt[in_rd]==max.
- in_ready = reset && !flush && !raw && !sat && (!out_valid || out_ready).
- stall_raw = in_valid && (raw || sat) && reset.
- Fire = in_valid && in_ready. Latency 1: on fire, the output register loads all in_* fields next cycle and out_valid=1.
- Draining: out_valid && out_ready && !fire → out_valid=0 next cycle. Simultaneous drain and fire → new entry replaces old, out_valid stays 1 (full throughput).
- Counter update per register r, all applied in the same cycle as a signed net delta:
  - +1 on fire with in_write_reg && in_rd==r.
  - -1 on wb_valid && wb_rd==r.
  - -1 on flush && out_valid && out_write_reg && out_rd==r.
- Counter rules:
  - r==0 never changes.
  - Result saturates at 0 (decrement at 0 is ignored) and never exceeds max; sat guarantees no overflow.
  - Increment and decrement on the same r in one cycle → unchanged.
  - Flush and wb on the same r → -2, floored at 0.
- Flush: out_valid=0 next cycle regardless of out_ready, and no fire that cycle. Instructions already past the output register are released through wb_valid.
- out_memory_read is carried only for downstream load handling; the hazard rule treats loads and ALU writers identically.

Optional Feature:
- Macro ISSUE_SCOREBOARD_BYPASS_EN.
- Defined: a source whose cnt==1 and which matches wb_rd with wb_valid in the same cycle is not busy, so issue fires in the writeback cycle.
- Undefined: that source is busy until the counter reads 0, costing one extra stall cycle.
- Counter arithmetic is identical in both builds.

Test Plan:
1. Reset low then high, in_valid=1, rs1=3 used, cnt all 0 → in_ready=1; out_valid=1 next cycle with payload echoed; out_* all 0 during reset.
2. Issue ADDI rd=5 (write_reg=1), then ADD rs1=5 → stall_raw=1 and no fire; wb_valid rd=5 → fires the same cycle with BYPASS_EN, one cycle later without.
3. Issue three writers to rd=7 with out_ready=1 (CNT_W=2) → cnt[7]=3; a fourth writer to rd=7 → sat stall; wb rd=7 → fourth issues.
4. Fire with in_rd=9 plus wb_valid wb_rd=9 in the same cycle, starting at cnt[9]=1 → cnt[9] stays 1.
5. out_valid=1 with out_rd=4 write_reg=1, assert flush with out_ready=0 → out_valid=0, cnt[4] back to 0, in_ready=0 that cycle.
6. in_rd=0 write_reg=1 issued repeatedly, then rs1=0 used → never stalls; wb_valid rd=12 with cnt[12]=0 → cnt[12] stays 0.
